deserializer: RTL and testbench

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_pkg.sv | 12 +
 rtl/deser_bit_cnt.sv | 22 ++
 rtl/deserializer.sv | 148 ++++++++++++++
 tb/tb_deserializer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/deserializer_pkg.sv
// Shared state encoding and default word width for the serial-to-parallel deserializer.
package deserializer_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

endpackage

// File: rtl/deser_bit_cnt.sv
// Bit-index down-counter: holds the position of the next expected serial bit.
module deser_bit_cnt
  import deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  input  logic             dec,
  output logic [SEL_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= SEL_W'(WIDTH - 1);
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - SEL_W'(1);
  end

endmodule

// File: rtl/deserializer.sv
// MSB-first serial-to-parallel deserializer with valid/ready output and overflow pulse.
// Optional even-parity trailer bit enabled by macro DESERIALIZER_PARITY_EN.
//   state  | meaning
//   IDLE   | no bits collected, sel = WIDTH-1
//   SHIFT  | partial word in shift register
//   PARITY | data complete, awaiting parity bit (DESERIALIZER_PARITY_EN only)
module deserializer
  import deserializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow
`ifdef DESERIALIZER_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  deser_state_t     state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] word_c, out_word;
  logic             cnt_load, cnt_dec, deliver;
  logic [SEL_W-1:0] cnt_val;
`ifdef DESERIALIZER_PARITY_EN
  logic             perr;
`endif

  deser_bit_cnt #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (sel)
  );

  always_comb begin
    word_c = sreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == SEL_W'(i)) word_c[i] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_load = 1'b0;
    cnt_val  = SEL_W'(WIDTH - 1);
    cnt_dec  = 1'b0;
    deliver  = 1'b0;
    out_word = word_c;
`ifdef DESERIALIZER_PARITY_EN
    perr     = 1'b0;
`endif
    if (din_valid) begin
      if (frame_start) begin
        // Restart: din becomes the MSB of a fresh word
        sreg_d            = '0;
        sreg_d[WIDTH-1]   = din;
        cnt_load          = 1'b1;
        cnt_val           = SEL_W'(WIDTH - 2);
        state_d           = SHIFT;
      end else begin
        case (state_q)
          IDLE, SHIFT: begin
            if (sel == '0) begin
`ifdef DESERIALIZER_PARITY_EN
              sreg_d  = word_c;
              state_d = PARITY;
`else
              deliver  = 1'b1;
              sreg_d   = '0;
              cnt_load = 1'b1;
              state_d  = IDLE;
`endif
            end else begin
              sreg_d  = word_c;
              cnt_dec = 1'b1;
              state_d = SHIFT;
            end
          end
`ifdef DESERIALIZER_PARITY_EN
          PARITY: begin
            deliver  = 1'b1;
            out_word = sreg_q;
            perr     = (^sreg_q) ^ din;
            sreg_d   = '0;
            cnt_load = 1'b1;
            state_d  = IDLE;
          end
`endif
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // A completed word is dropped only if the held word is still unconsumed
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      overflow <= 1'b0;
      if (deliver) begin
        if (!dout_valid || dout_ready) begin
          dout       <= out_word;
          dout_valid <= 1'b1;
`ifdef DESERIALIZER_PARITY_EN
          parity_err <= perr;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for the deserializer (WIDTH=4).
// With DESERIALIZER_PARITY_EN defined, each word is followed by its even-parity bit.
module tb_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic       dout_ready = 1'b0;
  logic [1:0] sel;
  logic [3:0] dout;
  logic       dout_valid;
  logic       overflow;
`ifdef DESERIALIZER_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  deserializer #(.WIDTH(4), .SEL_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .sel         (sel),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .overflow    (overflow)
`ifdef DESERIALIZER_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic d, input logic fs, input logic rdy);
    din_valid   = v;
    din         = d;
    frame_start = fs;
    dout_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  // Final data bit of word w, plus its even-parity bit when parity is enabled
  task automatic last_bit(input logic [3:0] w, input logic rdy);
    step(1'b1, w[0], 1'b0, rdy);
`ifdef DESERIALIZER_PARITY_EN
    step(1'b1, ^w, 1'b0, rdy);
`endif
  endtask

  initial begin
    // reset
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_sel", 32'(sel), 32'd3);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // 1010 with a din_valid gap (frame_start ignored while invalid)
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("w1_sel_after_b3", 32'(sel), 32'd2);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("w1_sel_after_b2", 32'(sel), 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("w1_sel_hold_gap", 32'(sel), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("w1_sel_after_b1", 32'(sel), 32'd0);
    chk("w1_valid_early", 32'(dout_valid), 32'd0);
    last_bit(4'b1010, 1'b1);
    chk("w1_dout", 32'(dout), 32'hA);
    chk("w1_valid", 32'(dout_valid), 32'd1);
    chk("w1_sel_reload", 32'(sel), 32'd3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1_consumed", 32'(dout_valid), 32'd0);

    // back-to-back 0011 then 1000, consumer accepts in the completion cycle
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    last_bit(4'b0011, 1'b1);
    chk("b2b_dout0", 32'(dout), 32'h3);
    chk("b2b_valid0", 32'(dout_valid), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("b2b_hold_dout", 32'(dout), 32'h3);
    chk("b2b_hold_valid", 32'(dout_valid), 32'd1);
`ifdef DESERIALIZER_PARITY_EN
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
`else
    step(1'b1, 1'b0, 1'b0, 1'b1);
`endif
    chk("b2b_dout1", 32'(dout), 32'h8);
    chk("b2b_valid1", 32'(dout_valid), 32'd1);
    chk("b2b_no_ovf", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_consumed", 32'(dout_valid), 32'd0);

    // overflow: 1010 held, 0011 dropped
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    last_bit(4'b1010, 1'b0);
    chk("ovf_first_dout", 32'(dout), 32'hA);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovf_not_yet", 32'(overflow), 32'd0);
    last_bit(4'b0011, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_dout_hold", 32'(dout), 32'hA);
    chk("ovf_valid_hold", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovf_pulse_end", 32'(overflow), 32'd0);
    chk("ovf_dout_hold2", 32'(dout), 32'hA);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_consumed", 32'(dout_valid), 32'd0);

    // frame_start discards partial 11, word 0110 follows
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("fs_sel", 32'(sel), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    last_bit(4'b0110, 1'b1);
    chk("fs_dout", 32'(dout), 32'h6);
    chk("fs_valid", 32'(dout_valid), 32'd1);
    chk("fs_no_ovf", 32'(overflow), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // mid-word reset, then 1000
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    chk("mrst_sel", 32'(sel), 32'd3);
    chk("mrst_dout", 32'(dout), 32'h0);
    chk("mrst_valid", 32'(dout_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    last_bit(4'b1000, 1'b1);
    chk("mrst_dout_new", 32'(dout), 32'h8);
    chk("mrst_valid_new", 32'(dout_valid), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef DESERIALIZER_PARITY_EN
    // parity mismatch then match on 1010
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("par_wait_valid", 32'(dout_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("par_bad_dout", 32'(dout), 32'hA);
    chk("par_bad_err", 32'(parity_err), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("par_ok_dout", 32'(dout), 32'hA);
    chk("par_ok_valid", 32'(dout_valid), 32'd1);
    chk("par_ok_err", 32'(parity_err), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
